// File: rtl/bomb_scheduler.sv
// Shared bomb-slot pool for both players: arbitrates place requests, runs fuses off the game tick
// and serialises expired bombs to the explosion logic. Define BOMB_SCHED_DUP_CHECK_EN to reject stacked bombs.
module bomb_scheduler #(
    parameter int unsigned SLOTS      = 6,
    parameter int unsigned FUSE_TICKS = 150,
    parameter int unsigned TW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       p1_req,
    input  logic [7:0] p1_coord,
    input  logic       p2_req,
    input  logic [7:0] p2_coord,
    output logic       p1_accept,
    output logic       p2_accept,
    output logic [2:0] bomb_num_1,
    output logic [2:0] bomb_num_2,
    output logic       full,
    output logic       exp_valid,
    output logic [7:0] exp_coord,
    output logic       exp_owner,
    input  logic       exp_ready
);
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 3;

    typedef enum logic [1:0] {S_FREE = 2'd0, S_ARMED = 2'd1, S_PENDING = 2'd2} slot_st_t;
    typedef enum logic {E_IDLE = 1'b0, E_PRESENT = 1'b1} exp_st_t;

    slot_st_t      st_q    [SLOTS];
    slot_st_t      st_d    [SLOTS];
    logic [TW-1:0] tmr_q   [SLOTS];
    logic [TW-1:0] tmr_d   [SLOTS];
    logic          own_q   [SLOTS];
    logic          own_d   [SLOTS];
    logic [CW-1:0] coord_q [SLOTS];
    logic [CW-1:0] coord_d [SLOTS];

    exp_st_t       exp_st_q, exp_st_d;
    logic [IW-1:0] exp_idx_q, exp_idx_d;
    logic          exp_valid_d;
    logic [CW-1:0] exp_coord_d;
    logic          exp_owner_d;
    logic          exp_fire;

    logic          rr_q, rr_d;
    logic [IW-1:0] free_cnt, free0, free1, pend_idx;
    logic          pend_any;
    logic          v1, v2, same;
    logic          win1, win2;
    logic [IW-1:0] slot1, slot2;
    logic [NW-1:0] num1_d, num2_d;
    logic          full_d;

    // Scan registered slot state: lowest two FREE slots, FREE count, lowest PENDING slot.
    always_comb begin
        free_cnt = '0;
        free0    = '0;
        free1    = '0;
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (st_q[i] == S_FREE) begin
                free_cnt = free_cnt + IW'(1);
                free1    = free0;
                free0    = IW'(i);
            end
            if (st_q[i] == S_PENDING) begin
                pend_any = 1'b1;
                pend_idx = IW'(i);
            end
        end
    end

    // Request qualification (optionally rejecting cells that already hold a bomb).
    always_comb begin
        v1   = p1_req;
        v2   = p2_req;
        same = 1'b0;
`ifdef BOMB_SCHED_DUP_CHECK_EN
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (st_q[i] != S_FREE) begin
                if (coord_q[i] == p1_coord) v1 = 1'b0;
                if (coord_q[i] == p2_coord) v2 = 1'b0;
            end
        end
        same = (p1_coord == p2_coord);
`endif
    end

    // Arbitration: both win when two slots are free, otherwise rr decides and flips to the loser.
    always_comb begin
        win1  = 1'b0;
        win2  = 1'b0;
        slot1 = free0;
        slot2 = free0;
        rr_d  = rr_q;
        if (free_cnt != '0) begin
            if (v1 && v2) begin
                if ((free_cnt >= IW'(2)) && !same) begin
                    win1  = 1'b1;
                    win2  = 1'b1;
                    slot2 = free1;
                end else begin
                    win1 = ~rr_q;
                    win2 = rr_q;
                    rr_d = ~rr_q;
                end
            end else begin
                win1 = v1;
                win2 = v2;
            end
        end
    end

    // Explosion FSM next state.
    always_comb begin
        exp_st_d    = exp_st_q;
        exp_idx_d   = exp_idx_q;
        exp_valid_d = exp_valid;
        exp_coord_d = exp_coord;
        exp_owner_d = exp_owner;
        exp_fire    = 1'b0;
        case (exp_st_q)
            E_IDLE: begin
                if (pend_any) begin
                    exp_st_d    = E_PRESENT;
                    exp_idx_d   = pend_idx;
                    exp_valid_d = 1'b1;
                    exp_coord_d = coord_q[pend_idx];
                    exp_owner_d = own_q[pend_idx];
                end
            end
            E_PRESENT: begin
                if (exp_ready) begin
                    exp_fire    = 1'b1;
                    exp_st_d    = E_IDLE;
                    exp_valid_d = 1'b0;
                end
            end
            default: exp_st_d = E_IDLE;
        endcase
    end

    // Slot next state: fuse countdown, release on handshake, allocation of winners.
    always_comb begin
        for (int i = 0; i < int'(SLOTS); i++) begin
            st_d[i]    = st_q[i];
            tmr_d[i]   = tmr_q[i];
            own_d[i]   = own_q[i];
            coord_d[i] = coord_q[i];
            if (tick && (st_q[i] == S_ARMED)) begin
                tmr_d[i] = tmr_q[i] - TW'(1);
                if (tmr_q[i] == TW'(1)) st_d[i] = S_PENDING;
            end
        end
        if (exp_fire) st_d[exp_idx_q] = S_FREE;
        if (win1) begin
            st_d[slot1]    = S_ARMED;
            tmr_d[slot1]   = TW'(FUSE_TICKS);
            own_d[slot1]   = 1'b0;
            coord_d[slot1] = p1_coord;
        end
        if (win2) begin
            st_d[slot2]    = S_ARMED;
            tmr_d[slot2]   = TW'(FUSE_TICKS);
            own_d[slot2]   = 1'b1;
            coord_d[slot2] = p2_coord;
        end
    end

    always_comb begin
        full_d = 1'b1;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (st_d[i] == S_FREE) full_d = 1'b0;
        end
        num1_d = bomb_num_1 + NW'(win1) - NW'(exp_fire && !exp_owner);
        num2_d = bomb_num_2 + NW'(win2) - NW'(exp_fire && exp_owner);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                st_q[i]    <= S_FREE;
                tmr_q[i]   <= '0;
                own_q[i]   <= 1'b0;
                coord_q[i] <= '0;
            end
            exp_st_q   <= E_IDLE;
            exp_idx_q  <= '0;
            exp_valid  <= 1'b0;
            exp_coord  <= '0;
            exp_owner  <= 1'b0;
            rr_q       <= 1'b0;
            p1_accept  <= 1'b0;
            p2_accept  <= 1'b0;
            bomb_num_1 <= '0;
            bomb_num_2 <= '0;
            full       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                st_q[i]    <= st_d[i];
                tmr_q[i]   <= tmr_d[i];
                own_q[i]   <= own_d[i];
                coord_q[i] <= coord_d[i];
            end
            exp_st_q   <= exp_st_d;
            exp_idx_q  <= exp_idx_d;
            exp_valid  <= exp_valid_d;
            exp_coord  <= exp_coord_d;
            exp_owner  <= exp_owner_d;
            rr_q       <= rr_d;
            p1_accept  <= win1;
            p2_accept  <= win2;
            bomb_num_1 <= num1_d;
            bomb_num_2 <= num2_d;
            full       <= full_d;
        end
    end

endmodule
